up_down_ctrl_f: RTL and testbench

Synchronous controller that sequences the level counter from the two raw push-buttons (up/down).
- Synchronizes and debounces both buttons, arbitrates simultaneous presses and generates single-cycle step commands, with auto-repeat on hold.
- Holds the saturating level register in the clk_f domain, replacing the button-clocked counter scheme.
- Sits between the board buttons and the display/actuator logic that consumes out_f.

---
 rtl/up_down_pkg_f.sv | 26 ++
 rtl/debounce_f.sv | 50 +++++
 rtl/up_down_ctrl_f.sv | 123 ++++++++++++
 tb/tb_up_down_ctrl_f.sv | 327 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/up_down_pkg_f.sv
// Shared types and constants for the up/down level controller.
// Key vectors are packed as {up, down}.
package up_down_pkg_f;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FIRE = 2'd1,
        HOLD = 2'd2
    } state_e;

    typedef enum logic {
        DIR_UP   = 1'b0,
        DIR_DOWN = 1'b1
    } dir_e;

    localparam logic [1:0] KEY_NONE = 2'b00;
    localparam logic [1:0] KEY_DOWN = 2'b01;
    localparam logic [1:0] KEY_UP   = 2'b10;
    localparam logic [1:0] KEY_BOTH = 2'b11;

    // Bits needed to count 0..n-1, never less than one.
    function automatic int unsigned cnt_width(input int unsigned n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/debounce_f.sv
// Two-flop synchronizer plus a vector-wide debouncer: the stable vector only
// follows the synchronized inputs after DB_CYCLES consecutive mismatching edges.
module debounce_f
    import up_down_pkg_f::*;
#(
    parameter int unsigned N         = 2,
    parameter int unsigned DB_CYCLES = 1
) (
    input  logic         clk_f,
    input  logic         reset_n_f,
    input  logic [N-1:0] raw_f,
    output logic [N-1:0] stable_f
);

    localparam int unsigned CW      = cnt_width(DB_CYCLES);
    localparam logic [CW-1:0] CntLast = CW'(DB_CYCLES - 1);

    logic [N-1:0]  sync1_q, sync2_q;
    logic [N-1:0]  stable_q, stable_d;
    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        stable_d = stable_q;
        cnt_d    = '0;
        if (sync2_q != stable_q) begin
            if (cnt_q == CntLast) begin
                stable_d = sync2_q;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk_f) begin
        if (!reset_n_f) begin
            sync1_q  <= '0;
            sync2_q  <= '0;
            stable_q <= '0;
            cnt_q    <= '0;
        end else begin
            sync1_q  <= raw_f;
            sync2_q  <= sync1_q;
            stable_q <= stable_d;
            cnt_q    <= cnt_d;
        end
    end

    assign stable_f = stable_q;

endmodule

// File: rtl/up_down_ctrl_f.sv
// Button-driven saturating level controller: debounced keys feed an
// IDLE/FIRE/HOLD sequencer with auto-repeat that steps the level register.
module up_down_ctrl_f
    import up_down_pkg_f::*;
#(
    parameter int unsigned WIDTH        = 3,
    parameter int unsigned DB_CYCLES    = 1000000,
    parameter int unsigned REPEAT_DELAY = 25000000,
    parameter int unsigned REPEAT_RATE  = 10000000
) (
    input  logic             clk_f,
    input  logic             reset_n_f,
    input  logic             up_f,
    input  logic             down_f,
    input  logic             enable_f,
    input  logic             clr_f,
    output logic [WIDTH-1:0] out_f,
    output logic             step_up_f,
    output logic             step_down_f,
    output logic             at_max_f,
    output logic             at_min_f
);

    localparam int unsigned RepMax = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
    localparam int unsigned RW     = cnt_width(RepMax);

    localparam logic [RW-1:0] RepDelayLoad = RW'(REPEAT_DELAY - 1);
    localparam logic [RW-1:0] RepRateLoad  = (REPEAT_RATE == 0) ? '0 : RW'(REPEAT_RATE - 1);
    localparam logic [WIDTH-1:0] LevelMax  = '1;

    logic [1:0]       key_stable;
    logic [1:0]       dir_key;
    state_e           state_q, state_d;
    dir_e             dir_q, dir_d;
    logic             rep_q, rep_d;
    logic [RW-1:0]    rep_cnt_q, rep_cnt_d;
    logic [WIDTH-1:0] out_q, out_d;

    debounce_f #(
        .N         (2),
        .DB_CYCLES (DB_CYCLES)
    ) u_debounce (
        .clk_f     (clk_f),
        .reset_n_f (reset_n_f),
        .raw_f     ({up_f, down_f}),
        .stable_f  (key_stable)
    );

    assign at_max_f = (out_q == LevelMax);
    assign at_min_f = (out_q == '0);
    assign out_f    = out_q;
    assign dir_key  = (dir_q == DIR_UP) ? KEY_UP : KEY_DOWN;

    always_comb begin
        state_d     = state_q;
        dir_d       = dir_q;
        rep_d       = rep_q;
        rep_cnt_d   = rep_cnt_q;
        step_up_f   = 1'b0;
        step_down_f = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (key_stable == KEY_UP) begin
                    state_d = FIRE;
                    dir_d   = DIR_UP;
                    rep_d   = 1'b0;
                end else if (key_stable == KEY_DOWN) begin
                    state_d = FIRE;
                    dir_d   = DIR_DOWN;
                    rep_d   = 1'b0;
                end
            end
            FIRE: begin
                step_up_f   = (dir_q == DIR_UP) & enable_f & ~at_max_f & ~clr_f;
                step_down_f = (dir_q == DIR_DOWN) & enable_f & ~at_min_f & ~clr_f;
                state_d     = HOLD;
                rep_cnt_d   = rep_q ? RepRateLoad : RepDelayLoad;
            end
            HOLD: begin
                // Any change away from the single held key ends the hold.
                if (key_stable != dir_key) begin
                    state_d = IDLE;
                end else if (rep_cnt_q == '0) begin
                    if (REPEAT_RATE != 0) begin
                        state_d = FIRE;
                        rep_d   = 1'b1;
                    end
                end else begin
                    rep_cnt_d = rep_cnt_q - 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        out_d = out_q;
        if (clr_f) begin
            out_d = '0;
        end else if (step_up_f) begin
            out_d = out_q + 1'b1;
        end else if (step_down_f) begin
            out_d = out_q - 1'b1;
        end
    end

    always_ff @(posedge clk_f) begin
        if (!reset_n_f) begin
            state_q   <= IDLE;
            dir_q     <= DIR_UP;
            rep_q     <= 1'b0;
            rep_cnt_q <= '0;
            out_q     <= '0;
        end else begin
            state_q   <= state_d;
            dir_q     <= dir_d;
            rep_q     <= rep_d;
            rep_cnt_q <= rep_cnt_d;
            out_q     <= out_d;
        end
    end

endmodule

// File: tb/tb_up_down_ctrl_f.sv
// Directed bench for up_down_ctrl_f with DB_CYCLES=4, REPEAT_DELAY=20,
// REPEAT_RATE=8, WIDTH=3; "edge k" is the k-th edge after stimulus is applied.
module tb_up_down_ctrl_f;
    import up_down_pkg_f::*;

    logic       clk_f = 1'b0;
    logic       reset_n_f;
    logic       up_f, down_f, enable_f, clr_f;
    logic [2:0] out_f;
    logic       step_up_f, step_down_f, at_max_f, at_min_f;

    int n_tests = 0;
    int n_fail  = 0;

    int       up_at[$];
    int       dn_at[$];
    logic [2:0] out_at[0:255];

    up_down_ctrl_f #(
        .WIDTH        (3),
        .DB_CYCLES    (4),
        .REPEAT_DELAY (20),
        .REPEAT_RATE  (8)
    ) dut (
        .clk_f       (clk_f),
        .reset_n_f   (reset_n_f),
        .up_f        (up_f),
        .down_f      (down_f),
        .enable_f    (enable_f),
        .clr_f       (clr_f),
        .out_f       (out_f),
        .step_up_f   (step_up_f),
        .step_down_f (step_down_f),
        .at_max_f    (at_max_f),
        .at_min_f    (at_min_f)
    );

    always #5 clk_f = ~clk_f;

    task automatic tick();
        @(posedge clk_f);
        #1;
    endtask

    task automatic record(input int k);
        out_at[k] = out_f;
        if (step_up_f) up_at.push_back(k);
        if (step_down_f) dn_at.push_back(k);
    endtask

    // Keys high for edges 0..hold-1, then released; sampled for `window` edges.
    task automatic run_press(input logic u, input logic d, input int hold, input int window);
        up_at.delete();
        dn_at.delete();
        up_f   = u;
        down_f = d;
        for (int k = 0; k < window; k++) begin
            if (k == hold) begin
                up_f   = 1'b0;
                down_f = 1'b0;
            end
            tick();
            record(k);
        end
        up_f   = 1'b0;
        down_f = 1'b0;
    endtask

    task automatic clear_level();
        clr_f = 1'b1;
        tick();
        clr_f = 1'b0;
    endtask

    task automatic test_reset();
        reset_n_f = 1'b0;
        up_f      = 1'b0;
        down_f    = 1'b0;
        enable_f  = 1'b1;
        clr_f     = 1'b0;
        repeat (3) tick();
        n_tests++;
        if (out_f !== 3'd0) begin
            n_fail++;
            $display("FAIL reset_out: got %0d expected 0", out_f);
        end
        n_tests++;
        if (step_up_f !== 1'b0 || step_down_f !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_steps: got up=%b down=%b expected 0 0", step_up_f, step_down_f);
        end
        n_tests++;
        if (at_min_f !== 1'b1 || at_max_f !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_flags: got min=%b max=%b expected 1 0", at_min_f, at_max_f);
        end
        n_tests++;
        if (dut.state_q !== IDLE) begin
            n_fail++;
            $display("FAIL reset_state: got %0d expected IDLE", dut.state_q);
        end
        reset_n_f = 1'b1;
        tick();
    endtask

    task automatic test_single_press();
        run_press(1'b1, 1'b0, 10, 30);
        n_tests++;
        if (up_at.size() != 1 || (up_at.size() > 0 ? up_at[0] : -1) != 6) begin
            n_fail++;
            $display("FAIL single_pulse: got %0d pulses first at %0d expected 1 at 6",
                     up_at.size(), up_at.size() > 0 ? up_at[0] : -1);
        end
        n_tests++;
        if (out_at[6] !== 3'd0 || out_at[7] !== 3'd1) begin
            n_fail++;
            $display("FAIL single_latency: got out@6=%0d out@7=%0d expected 0 1",
                     out_at[6], out_at[7]);
        end
        n_tests++;
        if (dn_at.size() != 0 || out_f !== 3'd1) begin
            n_fail++;
            $display("FAIL single_release: got down pulses=%0d out=%0d expected 0 1",
                     dn_at.size(), out_f);
        end
    endtask

    task automatic test_glitch();
        run_press(1'b1, 1'b0, 8, 24);
        run_press(1'b1, 1'b0, 8, 24);
        n_tests++;
        if (out_f !== 3'd3) begin
            n_fail++;
            $display("FAIL glitch_setup: got out=%0d expected 3", out_f);
        end
        run_press(1'b0, 1'b1, 3, 20);
        n_tests++;
        if (dn_at.size() != 0 || out_f !== 3'd3) begin
            n_fail++;
            $display("FAIL glitch_3cyc: got pulses=%0d out=%0d expected 0 3", dn_at.size(), out_f);
        end
        // A press of exactly DB_CYCLES cycles is the shortest one accepted.
        run_press(1'b0, 1'b1, 4, 20);
        n_tests++;
        if (dn_at.size() != 1 || (dn_at.size() > 0 ? dn_at[0] : -1) != 6 || out_f !== 3'd2) begin
            n_fail++;
            $display("FAIL glitch_4cyc: got pulses=%0d first=%0d out=%0d expected 1 6 2",
                     dn_at.size(), dn_at.size() > 0 ? dn_at[0] : -1, out_f);
        end
    endtask

    task automatic test_auto_repeat();
        int exp_at[5] = '{6, 27, 36, 45, 54};
        clear_level();
        n_tests++;
        if (out_f !== 3'd0 || at_min_f !== 1'b1) begin
            n_fail++;
            $display("FAIL clear_level: got out=%0d min=%b expected 0 1", out_f, at_min_f);
        end
        run_press(1'b1, 1'b0, 55, 75);
        n_tests++;
        if (up_at.size() != 5) begin
            n_fail++;
            $display("FAIL repeat_count: got %0d pulses expected 5", up_at.size());
        end
        for (int i = 0; i < 5; i++) begin
            n_tests++;
            if ((up_at.size() > i ? up_at[i] : -1) != exp_at[i]) begin
                n_fail++;
                $display("FAIL repeat_edge%0d: got %0d expected %0d",
                         i, up_at.size() > i ? up_at[i] : -1, exp_at[i]);
            end
        end
        n_tests++;
        if (out_f !== 3'd5) begin
            n_fail++;
            $display("FAIL repeat_out: got %0d expected 5", out_f);
        end
    endtask

    task automatic test_both_keys();
        up_at.delete();
        dn_at.delete();
        up_f   = 1'b1;
        down_f = 1'b1;
        for (int k = 0; k < 42; k++) begin
            if (k == 12) down_f = 1'b0;
            if (k == 24) up_f = 1'b0;
            tick();
            record(k);
        end
        n_tests++;
        if (up_at.size() != 1 || (up_at.size() > 0 ? up_at[0] : -1) != 18) begin
            n_fail++;
            $display("FAIL both_keys_up: got %0d pulses first at %0d expected 1 at 18",
                     up_at.size(), up_at.size() > 0 ? up_at[0] : -1);
        end
        n_tests++;
        if (dn_at.size() != 0 || out_f !== 3'd6) begin
            n_fail++;
            $display("FAIL both_keys_out: got down pulses=%0d out=%0d expected 0 6",
                     dn_at.size(), out_f);
        end
    endtask

    task automatic test_saturation();
        int exp_p;
        int exp_o;
        clear_level();
        for (int i = 1; i <= 9; i++) begin
            run_press(1'b1, 1'b0, 8, 24);
            exp_p = (i <= 7) ? 1 : 0;
            exp_o = (i <= 7) ? i : 7;
            n_tests++;
            if (up_at.size() != exp_p || out_f !== 3'(exp_o)) begin
                n_fail++;
                $display("FAIL sat_press%0d: got pulses=%0d out=%0d expected %0d %0d",
                         i, up_at.size(), out_f, exp_p, exp_o);
            end
        end
        n_tests++;
        if (at_max_f !== 1'b1 || at_min_f !== 1'b0) begin
            n_fail++;
            $display("FAIL sat_flags: got max=%b min=%b expected 1 0", at_max_f, at_min_f);
        end
        enable_f = 1'b0;
        run_press(1'b0, 1'b1, 8, 24);
        enable_f = 1'b1;
        n_tests++;
        if (dn_at.size() != 0 || out_f !== 3'd7) begin
            n_fail++;
            $display("FAIL disabled_press: got pulses=%0d out=%0d expected 0 7",
                     dn_at.size(), out_f);
        end
    endtask

    task automatic test_clr_fire();
        clear_level();
        for (int i = 0; i < 4; i++) run_press(1'b1, 1'b0, 8, 24);
        n_tests++;
        if (out_f !== 3'd4) begin
            n_fail++;
            $display("FAIL clr_setup: got out=%0d expected 4", out_f);
        end
        up_at.delete();
        dn_at.delete();
        up_f = 1'b1;
        for (int k = 0; k < 24; k++) begin
            if (k == 8) up_f = 1'b0;
            tick();
            clr_f = (k == 6);  // high during the FIRE cycle
            #1;
            record(k);
        end
        clr_f = 1'b0;
        n_tests++;
        if (up_at.size() != 0) begin
            n_fail++;
            $display("FAIL clr_fire_pulse: got %0d pulses expected 0", up_at.size());
        end
        n_tests++;
        if (out_at[6] !== 3'd4 || out_at[7] !== 3'd0 || out_f !== 3'd0) begin
            n_fail++;
            $display("FAIL clr_fire_out: got out@6=%0d out@7=%0d final=%0d expected 4 0 0",
                     out_at[6], out_at[7], out_f);
        end
    endtask

    task automatic test_reset_in_hold();
        clear_level();
        up_at.delete();
        dn_at.delete();
        up_f = 1'b1;
        for (int k = 0; k < 45; k++) begin
            reset_n_f = (k != 10);
            if (k == 30) up_f = 1'b0;
            tick();
            record(k);
            if (k == 10) begin
                n_tests++;
                if (out_f !== 3'd0 || dut.state_q !== IDLE || step_up_f !== 1'b0) begin
                    n_fail++;
                    $display("FAIL reset_hold_state: got out=%0d state=%0d step=%b expected 0 IDLE 0",
                             out_f, dut.state_q, step_up_f);
                end
            end
        end
        reset_n_f = 1'b1;
        n_tests++;
        if (out_at[7] !== 3'd1) begin
            n_fail++;
            $display("FAIL reset_hold_pre: got out@7=%0d expected 1", out_at[7]);
        end
        n_tests++;
        if (up_at.size() != 2 || (up_at.size() > 1 ? up_at[1] : -1) != 17) begin
            n_fail++;
            $display("FAIL reset_hold_restep: got %0d pulses second at %0d expected 2 at 17",
                     up_at.size(), up_at.size() > 1 ? up_at[1] : -1);
        end
        n_tests++;
        if (out_at[17] !== 3'd0 || out_f !== 3'd1) begin
            n_fail++;
            $display("FAIL reset_hold_out: got out@17=%0d final=%0d expected 0 1",
                     out_at[17], out_f);
        end
    endtask

    initial begin
        #500us;
        $display("FAIL watchdog: simulation did not finish within 500us");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_single_press();
        test_glitch();
        test_auto_repeat();
        test_both_keys();
        test_saturation();
        test_clr_fire();
        test_reset_in_hold();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
